// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 DIF FFT: sequencer states, size
// derivation and the parity bank mapping used by both the loader and the sequencer.
package fft_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD_PULSE = 3'd1;
    localparam logic [2:0] ST_LOAD_WAIT  = 3'd2;
    localparam logic [2:0] ST_COMPUTE    = 3'd3;
    localparam logic [2:0] ST_DRAIN      = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    function automatic int fft_size(input int r);
        return 1 << r;
    endfunction

    // Sample index parity selects the bank; the remaining low bits are the bank address.
    function automatic logic idx_parity(input logic [31:0] idx);
        return ^idx;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address generator: maps (stage, butterfly) to the
// conflict-free bank0/bank1 addresses, the bank swap flag and the twiddle address.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int R = 5
) (
    input  logic [2:0]   stage,
    input  logic [R-2:0] bfly,
    output logic [R-2:0] m0_addr,
    output logic [R-2:0] m1_addr,
    output logic         swap,
    output logic [R-2:0] tw_addr
);

    localparam int N = fft_size(R);

    logic [R-1:0] span;
    logic [R-1:0] low_mask;
    logic [R-1:0] b_ext;
    logic [R-1:0] p;
    logic [R-1:0] q;
    logic [R-1:0] tw_full;

    // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        span     = R'(N >> (stage + 3'd1));
        low_mask = span - R'(1);
        b_ext    = {1'b0, bfly};
        // Open a zero at the span bit: bits below stay, bits above move up by one.
        p        = ((b_ext & ~low_mask) << 1) | (b_ext & low_mask);
        q        = p | span;
        swap     = idx_parity(32'(p));
        if (swap) begin
            m0_addr = q[R-2:0];
            m1_addr = p[R-2:0];
        end else begin
            m0_addr = p[R-2:0];
            m1_addr = q[R-2:0];
        end
        tw_full  = (b_ext & low_mask) << stage;
        tw_addr  = tw_full[R-2:0];
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT sequencer: paces the bank loader, then walks R butterfly stages with a
// PIPE-deep write-back delay line and a drain gap between stages.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int R        = 5,
    parameter int INIT_GAP = 6,
    parameter int PIPE     = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_BI_en,
    output logic [2:0]   o_stage,
    output logic         o_rd_en,
    output logic [R-2:0] o_m0_rd_addr,
    output logic [R-2:0] o_m1_rd_addr,
    output logic         o_rd_swap,
    output logic [R-2:0] o_tw_addr,
    output logic         o_wr_en,
    output logic [R-2:0] o_m0_wr_addr,
    output logic [R-2:0] o_m1_wr_addr,
    output logic         o_wr_swap
);

    localparam int              N           = fft_size(R);
    localparam int              CW          = 8;
    localparam logic [CW-1:0]   GAP_LAST    = CW'(INIT_GAP - 2);
    localparam logic [CW-1:0]   DRAIN_LAST  = CW'(PIPE - 1);
    localparam logic [R:0]      SAMPLE_LAST = (R+1)'(N - 1);
    localparam logic [R-2:0]    BFLY_LAST   = '1;
    localparam logic [2:0]      STAGE_LAST  = 3'(R - 1);

    logic [2:0]    state;
    logic [R:0]    sample_cnt;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    stage;
    logic [R-2:0]  bfly;

    logic [R-2:0]  ag_m0, ag_m1, ag_tw;
    logic          ag_swap;
    logic          rd_en;

    logic [PIPE-1:0] dl_en;
    logic [PIPE-1:0] dl_swap;
    logic [R-2:0]    dl_m0 [PIPE];
    logic [R-2:0]    dl_m1 [PIPE];

    fft_bf_addr_gen #(.R(R)) u_addr_gen (
        .stage   (stage),
        .bfly    (bfly),
        .m0_addr (ag_m0),
        .m1_addr (ag_m1),
        .swap    (ag_swap),
        .tw_addr (ag_tw)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            wait_cnt   <= '0;
            stage      <= '0;
            bfly       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sample_cnt <= '0;
                    stage      <= '0;
                    bfly       <= '0;
                    if (i_start) state <= ST_LOAD_PULSE;
                end
                ST_LOAD_PULSE: begin
                    wait_cnt <= '0;
                    state    <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (wait_cnt == GAP_LAST) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == SAMPLE_LAST) begin
                            stage <= '0;
                            bfly  <= '0;
                            state <= ST_COMPUTE;
                        end else begin
                            state <= ST_LOAD_PULSE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (bfly == BFLY_LAST) begin
                        bfly     <= '0;
                        wait_cnt <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        bfly <= bfly + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Hold off the next stage until the last write-back of this one has landed.
                    if (wait_cnt == DRAIN_LAST) begin
                        if (stage == STAGE_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            stage <= stage + 3'd1;
                            state <= ST_COMPUTE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_en        = (state == ST_COMPUTE);
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);
    assign o_BI_en      = (state == ST_LOAD_PULSE);
    assign o_stage      = stage;
    assign o_rd_en      = rd_en;
    assign o_m0_rd_addr = rd_en ? ag_m0 : '0;
    assign o_m1_rd_addr = rd_en ? ag_m1 : '0;
    assign o_rd_swap    = rd_en & ag_swap;
    assign o_tw_addr    = rd_en ? ag_tw : '0;

    // NOTE: the delay line is reset explicitly so a reset mid-stage cannot leak a stray write-back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dl_en   <= '0;
            dl_swap <= '0;
            for (int i = 0; i < PIPE; i++) begin
                dl_m0[i] <= '0;
                dl_m1[i] <= '0;
            end
        end else begin
            dl_en[0]   <= o_rd_en;
            dl_swap[0] <= o_rd_swap;
            dl_m0[0]   <= o_m0_rd_addr;
            dl_m1[0]   <= o_m1_rd_addr;
            for (int i = 1; i < PIPE; i++) begin
                dl_en[i]   <= dl_en[i-1];
                dl_swap[i] <= dl_swap[i-1];
                dl_m0[i]   <= dl_m0[i-1];
                dl_m1[i]   <= dl_m1[i-1];
            end
        end
    end

    assign o_wr_en      = dl_en[PIPE-1];
    assign o_wr_swap    = dl_swap[PIPE-1];
    assign o_m0_wr_addr = dl_m0[PIPE-1];
    assign o_m1_wr_addr = dl_m1[PIPE-1];

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: expected loader pulses, reads, writes and done
// are queued when start is issued; a negedge monitor pops and compares them.
module tb_fft_seq_ctrl;

    localparam int R        = 5;
    localparam int INIT_GAP = 6;
    localparam int PIPE     = 4;
    localparam int N        = 1 << R;
    localparam int AW       = R - 1;

    typedef struct {
        int cyc;
        int s;
        int b;
        int m0;
        int m1;
        int swap;
        int tw;
    } bf_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          o_busy, o_done, o_BI_en, o_rd_en, o_rd_swap, o_wr_en, o_wr_swap;
    logic [2:0]    o_stage;
    logic [AW-1:0] o_m0_rd_addr, o_m1_rd_addr, o_tw_addr, o_m0_wr_addr, o_m1_wr_addr;
    logic [29:0]   all_outs;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  start_cyc, busy_cnt, wr_cnt, done_cyc, last_bi_cyc, first_rd_cyc;
    int  bi_q[$];
    int  done_q[$];
    bf_t rd_q[$];
    bf_t wr_q[$];

    // Hand-computed vectors: stage, butterfly, m0, m1, swap, twiddle.
    int vec_s[3]    = '{0, 1, 4};
    int vec_b[3]    = '{3, 5, 7};
    int vec_m0[3]   = '{3, 5, 15};
    int vec_m1[3]   = '{3, 13, 14};
    int vec_swap[3] = '{0, 0, 1};
    int vec_tw[3]   = '{3, 10, 0};

    fft_seq_ctrl #(.R(R), .INIT_GAP(INIT_GAP), .PIPE(PIPE)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_BI_en      (o_BI_en),
        .o_stage      (o_stage),
        .o_rd_en      (o_rd_en),
        .o_m0_rd_addr (o_m0_rd_addr),
        .o_m1_rd_addr (o_m1_rd_addr),
        .o_rd_swap    (o_rd_swap),
        .o_tw_addr    (o_tw_addr),
        .o_wr_en      (o_wr_en),
        .o_m0_wr_addr (o_m0_wr_addr),
        .o_m1_wr_addr (o_m1_wr_addr),
        .o_wr_swap    (o_wr_swap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign all_outs = {o_busy, o_done, o_BI_en, o_stage, o_rd_en, o_m0_rd_addr, o_m1_rd_addr,
                       o_rd_swap, o_tw_addr, o_wr_en, o_m0_wr_addr, o_m1_wr_addr, o_wr_swap};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got an output at cycle %0d, required none", name, cyc);
    endtask

    // Bit-by-bit reference: spread b's bits around the empty position, count ones for parity.
    function automatic bf_t bf_model(input int s, input int b);
        bf_t e;
        int  pos, p, q, j, ones;
        pos = R - 1 - s;
        p = 0;
        j = 0;
        for (int i = 0; i < R; i++) begin
            if (i != pos) begin
                p = p | (((b >> j) & 1) << i);
                j++;
            end
        end
        q = p + (1 << pos);
        ones = 0;
        for (int i = 0; i < R; i++) ones += (p >> i) & 1;
        e.s    = s;
        e.b    = b;
        e.swap = ones % 2;
        e.m0   = (e.swap == 0) ? p % (N / 2) : q % (N / 2);
        e.m1   = (e.swap == 0) ? q % (N / 2) : p % (N / 2);
        e.tw   = ((b % (1 << pos)) * (1 << s)) % (N / 2);
        e.cyc  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (o_busy) busy_cnt++;
        if (o_BI_en) begin
            last_bi_cyc = cyc;
            if (bi_q.size() == 0) unexpected("bi_en");
            else check("bi_en_cycle", 64'(cyc), 64'(bi_q.pop_front()));
        end
        if (o_rd_en) begin
            bf_t e;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (rd_q.size() == 0) unexpected("rd_en");
            else begin
                e = rd_q.pop_front();
                check($sformatf("rd s%0d b%0d", e.s, e.b),
                      64'({cyc, o_stage, o_m0_rd_addr, o_m1_rd_addr, o_rd_swap, o_tw_addr}),
                      64'({e.cyc, 3'(e.s), AW'(e.m0), AW'(e.m1), 1'(e.swap), AW'(e.tw)}));
                for (int k = 0; k < 3; k++) begin
                    if (e.s == vec_s[k] && e.b == vec_b[k])
                        check($sformatf("vector s%0d b%0d", vec_s[k], vec_b[k]),
                              64'({o_m0_rd_addr, o_m1_rd_addr, o_rd_swap, o_tw_addr}),
                              64'({AW'(vec_m0[k]), AW'(vec_m1[k]), 1'(vec_swap[k]), AW'(vec_tw[k])}));
                end
            end
        end
        if (o_wr_en) begin
            bf_t e;
            wr_cnt++;
            if (wr_q.size() == 0) unexpected("wr_en");
            else begin
                e = wr_q.pop_front();
                check($sformatf("wr s%0d b%0d", e.s, e.b),
                      64'({cyc, o_m0_wr_addr, o_m1_wr_addr, o_wr_swap}),
                      64'({e.cyc, AW'(e.m0), AW'(e.m1), 1'(e.swap)}));
            end
        end
        if (o_done) begin
            done_cyc = cyc;
            if (done_q.size() == 0) unexpected("done");
            else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
    end

    task automatic issue_start();
        bf_t e;
        busy_cnt     = 0;
        wr_cnt       = 0;
        done_cyc     = -1;
        last_bi_cyc  = -1;
        first_rd_cyc = -1;
        @(negedge clk);
        start_cyc = cyc;
        for (int j = 0; j < N; j++) bi_q.push_back(start_cyc + 1 + INIT_GAP * j);
        for (int s = 0; s < R; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                e = bf_model(s, b);
                e.cyc = start_cyc + 1 + N * INIT_GAP + s * (N / 2 + PIPE) + b;
                rd_q.push_back(e);
                e.cyc = e.cyc + PIPE;
                wr_q.push_back(e);
            end
        end
        done_q.push_back(start_cyc + 1 + N * INIT_GAP + R * (N / 2 + PIPE));
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run_full();
        issue_start();
        // Extra start requests during load, compute and the final drain must be ignored.
        repeat (310) begin
            @(negedge clk);
            i_start = ((cyc - start_cyc) inside {50, 200, 292});
        end
        i_start = 1'b0;
        check("bi_en_missing", 64'(bi_q.size()), 64'd0);
        check("rd_missing", 64'(rd_q.size()), 64'd0);
        check("wr_missing", 64'(wr_q.size()), 64'd0);
        check("done_missing", 64'(done_q.size()), 64'd0);
        check("latency_cycles_incl_start", 64'(done_cyc - start_cyc + 1), 64'd294);
        check("first_rd_after_last_bi", 64'(first_rd_cyc - last_bi_cyc), 64'(INIT_GAP));
        check("wr_count", 64'(wr_cnt), 64'd80);
        check("busy_cycles", 64'(busy_cnt), 64'd293);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(all_outs), 64'd0);
        i_rst = 1'b0;
        @(negedge clk);

        run_full();

        // Reset for one cycle in the middle of stage 0.
        issue_start();
        repeat (199) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("midrun_reset_outputs", 64'(all_outs), 64'd0);
        bi_q.delete();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        wr_cnt = 0;
        repeat (PIPE + 2) @(negedge clk);
        check("midrun_reset_no_wr", 64'(wr_cnt), 64'd0);
        check("midrun_reset_idle", 64'(o_busy), 64'd0);

        run_full();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
